// File: rtl/management_rx_frame_buffer_pkg.sv
// Shared types, constants and helpers for the management RX frame buffer.
// MGMT_RX_PERF_COUNTERS_EN (when defined) builds the perf_* counters.
package mgmt_rx_pkg;

    typedef logic [10:0] framelen_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD
    } rx_wstate_t;

    localparam int MAX_FRAME_DEFAULT = 2047;

`ifdef MGMT_RX_PERF_COUNTERS_EN
    localparam bit PERF_COUNTERS_EN = 1'b1;
`else
    localparam bit PERF_COUNTERS_EN = 1'b0;
`endif

    // Number of 32-bit words a frame of len bytes occupies in the data RAM.
    function automatic logic [9:0] frame_words(input framelen_t len);
        return 10'(({1'b0, len} + 12'd3) >> 2);
    endfunction

endpackage

// File: rtl/management_rx_frame_buffer_if.sv
// RX word stream, MCU byte-read port and perf counters of the management RX frame buffer.
interface management_rx_frame_buffer_if;
    import mgmt_rx_pkg::*;

    logic        rx_start;
    logic        rx_data_valid;
    logic [2:0]  rx_bytes_valid;
    logic [31:0] rx_data;
    logic        rx_commit;
    logic        rx_drop;

    logic        rd_frame_valid;
    framelen_t   rd_frame_len;
    logic        rd_en;
    logic        rd_data_valid;
    logic [7:0]  rd_data;
    logic        rd_pop;

    logic [31:0] perf_frames_ok;
    logic [31:0] perf_frames_ovf;
    logic [31:0] perf_frames_bad;

    modport master (
        output rx_start, rx_data_valid, rx_bytes_valid, rx_data, rx_commit, rx_drop,
        output rd_en, rd_pop,
        input  rd_frame_valid, rd_frame_len, rd_data_valid, rd_data,
        input  perf_frames_ok, perf_frames_ovf, perf_frames_bad
    );

    modport slave (
        input  rx_start, rx_data_valid, rx_bytes_valid, rx_data, rx_commit, rx_drop,
        input  rd_en, rd_pop,
        output rd_frame_valid, rd_frame_len, rd_data_valid, rd_data,
        output perf_frames_ok, perf_frames_ovf, perf_frames_bad
    );

endinterface

// File: rtl/management_rx_frame_buffer_len_fifo.sv
// Single-clock frame-length FIFO; dout is a registered read of the head entry.
module mgmt_rx_len_fifo
    import mgmt_rx_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  framelen_t din,
    input  logic      pop,
    output framelen_t dout,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    framelen_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
            // A pop shows up here one cycle after rd_ptr moves.
            dout <= mem[rd_ptr];
        end
    end

    // NOTE: storage arrays carry no reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/management_rx_frame_buffer.sv
// Management 10G RX frame store: commits/rolls back whole frames, serves them bytewise to the MCU.
// MGMT_RX_PERF_COUNTERS_EN (when defined) builds the saturating perf_* counters.
module management_rx_frame_buffer
    import mgmt_rx_pkg::*;
#(
    parameter int DATA_DEPTH = 1024,
    parameter int LEN_DEPTH  = 32,
    parameter int MAX_FRAME  = MAX_FRAME_DEFAULT
) (
    input logic                          sys_clk,
    input logic                          sys_rst,
    management_rx_frame_buffer_if.slave  bus
);

    localparam int AW = $clog2(DATA_DEPTH);
    typedef logic [AW-1:0] ptr_t;

    rx_wstate_t  wstate;
    ptr_t        wr_ptr;
    ptr_t        commit_ptr;
    ptr_t        rd_base;
    ptr_t        rd_addr;
    framelen_t   byte_cnt;
    logic [11:0] next_cnt;
    logic        ram_full;
    logic        len_full;
    logic        len_empty;
    framelen_t   len_head;
    logic        ram_we;
    logic        len_push;
    logic        ovf_hit;

    logic [31:0] ram [DATA_DEPTH];
    logic [31:0] ram_q;

    framelen_t   rd_idx;
    logic        frame_valid;
    logic        rd_fire;
    logic        pop_fire;
    logic        pop_d1;
    logic        s1_valid;
    logic        s1_past;
    logic [1:0]  s1_lane;
    logic [7:0]  lane_byte;
    logic [7:0]  rd_byte;
    logic        rd_byte_valid;

    // Full is judged against rd_base so the unpopped head frame is never overwritten.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_cnt = {1'b0, byte_cnt} + {9'd0, bus.rx_bytes_valid};
        ram_full = ((wr_ptr + ptr_t'(1)) == rd_base);
        ram_we   = 1'b0;
        len_push = 1'b0;
        ovf_hit  = 1'b0;
        if (!bus.rx_start && wstate == RECV) begin
            if (bus.rx_commit) begin
                if (len_full) ovf_hit  = 1'b1;
                else          len_push = 1'b1;
            end else if (!bus.rx_drop && bus.rx_data_valid) begin
                if (ram_full || next_cnt > 12'(MAX_FRAME) || len_full) ovf_hit = 1'b1;
                else                                                    ram_we  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wstate     <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            byte_cnt   <= '0;
        end else if (bus.rx_start) begin
            wr_ptr   <= commit_ptr;
            byte_cnt <= '0;
            wstate   <= RECV;
        end else begin
            case (wstate)
                RECV: begin
                    if (bus.rx_commit) begin
                        if (len_push) commit_ptr <= wr_ptr;
                        else          wr_ptr     <= commit_ptr;
                        wstate <= IDLE;
                    end else if (bus.rx_drop) begin
                        wr_ptr <= commit_ptr;
                        wstate <= IDLE;
                    end else if (ram_we) begin
                        wr_ptr   <= wr_ptr + ptr_t'(1);
                        byte_cnt <= next_cnt[10:0];
                    end else if (ovf_hit) begin
                        wstate <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.rx_commit || bus.rx_drop) begin
                        wr_ptr <= commit_ptr;
                        wstate <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (ram_we) ram[wr_ptr] <= bus.rx_data;
        ram_q <= ram[rd_addr];
    end

    mgmt_rx_len_fifo #(
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (len_push),
        .din   (byte_cnt),
        .pop   (pop_fire),
        .dout  (len_head),
        .empty (len_empty),
        .full  (len_full)
    );

    assign rd_fire  = bus.rd_en && frame_valid && !bus.rd_pop;
    assign pop_fire = bus.rd_pop && frame_valid;
    assign rd_addr  = rd_base + ptr_t'(rd_idx[10:2]);

    always_comb begin
        lane_byte = ram_q[31:24];
        case (s1_lane)
            2'd1:    lane_byte = ram_q[23:16];
            2'd2:    lane_byte = ram_q[15:8];
            2'd3:    lane_byte = ram_q[7:0];
            default: ;
        endcase
    end

    // pop_d1 holds frame_valid low one extra cycle while the length FIFO head refreshes.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_base       <= '0;
            rd_idx        <= '0;
            frame_valid   <= 1'b0;
            pop_d1        <= 1'b0;
            s1_valid      <= 1'b0;
            s1_past       <= 1'b0;
            s1_lane       <= '0;
            rd_byte       <= '0;
            rd_byte_valid <= 1'b0;
        end else begin
            pop_d1      <= pop_fire;
            frame_valid <= !len_empty && !pop_fire && !pop_d1;
            if (pop_fire) begin
                rd_base <= rd_base + ptr_t'(frame_words(len_head));
                rd_idx  <= '0;
            end else if (rd_fire && rd_idx < len_head) begin
                rd_idx <= rd_idx + 11'd1;
            end
            s1_valid      <= rd_fire;
            s1_past       <= (rd_idx >= len_head);
            s1_lane       <= rd_idx[1:0];
            rd_byte_valid <= s1_valid;
            rd_byte       <= (s1_valid && !s1_past) ? lane_byte : 8'h00;
        end
    end

    assign bus.rd_frame_valid = frame_valid;
    assign bus.rd_frame_len   = len_head;
    assign bus.rd_data_valid  = rd_byte_valid;
    assign bus.rd_data        = rd_byte;

`ifdef MGMT_RX_PERF_COUNTERS_EN
    logic [31:0] cnt_ok;
    logic [31:0] cnt_ovf;
    logic [31:0] cnt_bad;
    logic        bad_hit;

    assign bad_hit = !bus.rx_start && wstate == RECV && !bus.rx_commit && bus.rx_drop;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_ok  <= '0;
            cnt_ovf <= '0;
            cnt_bad <= '0;
        end else begin
            if (len_push && cnt_ok  != '1) cnt_ok  <= cnt_ok  + 32'd1;
            if (ovf_hit  && cnt_ovf != '1) cnt_ovf <= cnt_ovf + 32'd1;
            if (bad_hit  && cnt_bad != '1) cnt_bad <= cnt_bad + 32'd1;
        end
    end

    assign bus.perf_frames_ok  = cnt_ok;
    assign bus.perf_frames_ovf = cnt_ovf;
    assign bus.perf_frames_bad = cnt_bad;
`else
    assign bus.perf_frames_ok  = '0;
    assign bus.perf_frames_ovf = '0;
    assign bus.perf_frames_bad = '0;
`endif

endmodule

// File: tb/tb_management_rx_frame_buffer.sv
// Directed bench: dut_a (64-word RAM) for the main flows, dut_b (16-word RAM) for RAM overflow.
module tb_management_rx_frame_buffer;
    import mgmt_rx_pkg::*;

    localparam bit PE = PERF_COUNTERS_EN;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        sel_b;
    logic        rx_start, rx_data_valid, rx_commit, rx_drop, rd_en, rd_pop;
    logic [2:0]  rx_bytes_valid;
    logic [31:0] rx_data;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    management_rx_frame_buffer_if ifa ();
    management_rx_frame_buffer_if ifb ();

    assign ifa.rx_start       = rx_start && !sel_b;
    assign ifa.rx_data_valid  = rx_data_valid && !sel_b;
    assign ifa.rx_commit      = rx_commit && !sel_b;
    assign ifa.rx_drop        = rx_drop && !sel_b;
    assign ifa.rd_en          = rd_en && !sel_b;
    assign ifa.rd_pop         = rd_pop && !sel_b;
    assign ifa.rx_bytes_valid = rx_bytes_valid;
    assign ifa.rx_data        = rx_data;

    assign ifb.rx_start       = rx_start && sel_b;
    assign ifb.rx_data_valid  = rx_data_valid && sel_b;
    assign ifb.rx_commit      = rx_commit && sel_b;
    assign ifb.rx_drop        = rx_drop && sel_b;
    assign ifb.rd_en          = rd_en && sel_b;
    assign ifb.rd_pop         = rd_pop && sel_b;
    assign ifb.rx_bytes_valid = rx_bytes_valid;
    assign ifb.rx_data        = rx_data;

    management_rx_frame_buffer #(.DATA_DEPTH(64), .LEN_DEPTH(32), .MAX_FRAME(2047)) dut_a (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .bus     (ifa)
    );

    management_rx_frame_buffer #(.DATA_DEPTH(16), .LEN_DEPTH(32), .MAX_FRAME(2047)) dut_b (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .bus     (ifb)
    );

    logic        o_fv, o_dv;
    framelen_t   o_len;
    logic [7:0]  o_data;
    logic [31:0] o_ok, o_ovf, o_bad;

    assign o_fv   = sel_b ? ifb.rd_frame_valid  : ifa.rd_frame_valid;
    assign o_len  = sel_b ? ifb.rd_frame_len    : ifa.rd_frame_len;
    assign o_dv   = sel_b ? ifb.rd_data_valid   : ifa.rd_data_valid;
    assign o_data = sel_b ? ifb.rd_data         : ifa.rd_data;
    assign o_ok   = sel_b ? ifb.perf_frames_ok  : ifa.perf_frames_ok;
    assign o_ovf  = sel_b ? ifb.perf_frames_ovf : ifa.perf_frames_ovf;
    assign o_bad  = sel_b ? ifb.perf_frames_bad : ifa.perf_frames_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int seed, input int k, input int len);
        return (k < len) ? 8'(seed + k) : 8'h00;
    endfunction

    function automatic logic [31:0] perf(input int n);
        return PE ? 32'(n) : 32'd0;
    endfunction

    task automatic idle_inputs();
        rx_start = 0; rx_data_valid = 0; rx_commit = 0; rx_drop = 0;
        rd_en = 0; rd_pop = 0; rx_bytes_valid = 0; rx_data = 0;
    endtask

    // Byte k of a frame is seed+k; lanes past the end carry 8'hEE filler.
    task automatic send_frame(input int nbytes, input int seed, input bit commit);
        @(negedge clk); rx_start = 1;
        @(negedge clk); rx_start = 0;
        for (int w = 0; w < (nbytes + 3) / 4; w++) begin
            int rem;
            rem = nbytes - 4 * w;
            rx_data_valid  = 1;
            rx_bytes_valid = 3'((rem >= 4) ? 4 : rem);
            for (int l = 0; l < 4; l++)
                rx_data[31 - 8 * l -: 8] = (4 * w + l < nbytes) ? 8'(seed + 4 * w + l) : 8'hEE;
            @(negedge clk);
        end
        rx_data_valid = 0;
        if (commit) rx_commit = 1; else rx_drop = 1;
        @(negedge clk); rx_commit = 0; rx_drop = 0;
    endtask

    // Streams len+extra back-to-back rd_en; data must appear exactly 2 cycles after each.
    task automatic read_frame(input int len, input int seed, input int extra);
        int n;
        n = len + extra;
        @(negedge clk);
        check("frame_valid", 32'(o_fv), 32'd1);
        check("frame_len", 32'(o_len), 32'(len));
        for (int c = 0; c < n + 2; c++) begin
            if (c > 0) @(negedge clk);
            check("rd_valid", 32'(o_dv), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) check("rd_data", 32'(o_data), 32'(exp_byte(seed, c - 2, len)));
            rd_en = (c < n);
        end
        rd_en = 0;
    endtask

    task automatic pop_frame(input bit more);
        @(negedge clk); rd_pop = 1;
        @(negedge clk); rd_pop = 0;
        check("pop_fv_t1", 32'(o_fv), 32'd0);
        @(negedge clk);
        check("pop_fv_t2", 32'(o_fv), 32'd0);
        @(negedge clk);
        check("pop_fv_t3", 32'(o_fv), 32'(more));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        sel_b   = 0;
        sys_rst = 1;
        repeat (3) @(negedge clk);
        sys_rst = 0;
        @(negedge clk);
        check("rst_fv", 32'(o_fv), 32'd0);
        check("rst_len", 32'(o_len), 32'd0);
        check("rst_dv", 32'(o_dv), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_ok", o_ok, 32'd0);

        // 60-byte frame, exact length
        send_frame(60, 8'h10, 1);
        read_frame(60, 8'h10, 0);
        pop_frame(0);
        check("t1_ok", o_ok, perf(1));

        // 61-byte frame, last byte AB, reads past the end return 00
        send_frame(61, 111, 1);
        read_frame(61, 111, 2);
        pop_frame(0);

        // A committed, B dropped, C committed over B's space
        send_frame(20, 8'h30, 1);
        send_frame(12, 8'h50, 0);
        send_frame(9, 8'h70, 1);
        read_frame(20, 8'h30, 0);
        pop_frame(1);
        read_frame(9, 8'h70, 0);
        pop_frame(0);
        check("t3_bad", o_bad, perf(1));
        rd_en = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("idle_rd_valid", 32'(o_dv), 32'd0);
        end
        rd_en = 0;

        // 33 one-word frames: length FIFO overflows on the last, RAM pointer wraps
        for (int i = 0; i < 33; i++) send_frame(1 + i % 4, 8'h80 + i, 1);
        @(negedge clk);
        check("t5_ovf", o_ovf, perf(1));
        check("t5_ok", o_ok, perf(36));
        for (int i = 0; i < 32; i++) begin
            read_frame(1 + i % 4, 8'h80 + i, 0);
            pop_frame(i < 31);
        end

        // 16-word RAM: 80-byte frame overflows, next 16-byte frame fits
        sel_b = 1;
        send_frame(80, 8'h90, 1);
        @(negedge clk);
        @(negedge clk);
        check("t4_fv", 32'(o_fv), 32'd0);
        check("t4_ovf", o_ovf, perf(1));
        check("t4_ok", o_ok, perf(0));
        send_frame(16, 8'hA0, 1);
        read_frame(16, 8'hA0, 0);
        pop_frame(0);
        check("t4_ok2", o_ok, perf(1));

        // Reset mid-frame and mid-read
        sel_b = 0;
        send_frame(8, 8'hC0, 1);
        @(negedge clk);
        check("t6_fv", 32'(o_fv), 32'd1);
        rx_start = 1; rd_en = 1;
        @(negedge clk);
        rx_start = 0; rx_data_valid = 1; rx_bytes_valid = 3'd4; rx_data = 32'h1234_5678;
        @(negedge clk);
        sys_rst = 1;
        @(negedge clk);
        check("t6_fv0", 32'(o_fv), 32'd0);
        check("t6_len0", 32'(o_len), 32'd0);
        check("t6_dv0", 32'(o_dv), 32'd0);
        check("t6_data0", 32'(o_data), 32'd0);
        check("t6_ok0", o_ok, 32'd0);
        check("t6_ovf0", o_ovf, 32'd0);
        check("t6_bad0", o_bad, 32'd0);
        sys_rst = 0;
        idle_inputs();
        send_frame(12, 8'hD0, 1);
        read_frame(12, 8'hD0, 0);
        pop_frame(0);
        check("t6_ok1", o_ok, perf(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
